// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS timer.
//   - FSM state encodings (exposed on the state output, so the values are fixed).
//   - Active-high 7-segment patterns for 0..9, bit0 = a .. bit6 = g.
//   - to_bcd: binary 0..99 to {tens, ones}.
package timer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_RUN     = 3'b001;
  localparam logic [2:0] ST_PAUSE   = 3'b010;
  localparam logic [2:0] ST_CLEAR   = 3'b011;
  localparam logic [2:0] ST_EXPIRED = 3'b100;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_PATTERN [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Constant divisors; only values 0..99 reach this, so both digits fit in 4 bits.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Ports:
//   digit_i  4-bit digit; values 10..15 blank the digit.
//   seg_o    7-bit pattern, bit0 = a .. bit6 = g, 1 = segment lit.
module seg7_digit_decoder
  import timer_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (digit_i <= 4'd9) seg_o = SEG_PATTERN[digit_i];
  end

endmodule

// File: rtl/mmss_timer_display.sv
// MM:SS up/down timer with preset load, countdown expiry alarm and lap freeze.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start/pause/clear   level run controls, priority clear > pause > start
//   mode                0 = up, 1 = down; captured when RUN is entered from IDLE
//   load, preset_*      preset load, honoured in IDLE only, clamped to MAX_MIN:59
//   lap                 rising edge in RUN freezes the display while counting goes on
//   seg1..seg4          MM tens, MM ones, SS tens, SS ones (polarity per SEG_ACTIVE_LOW)
//   state, led, expired FSM state, tick/alarm indicator, EXPIRED flag
// Every output comes straight from a register.
module mmss_timer_display
  import timer_pkg::*;
#(
  parameter int TICK_DIV       = 50000000,
  parameter int BLINK_DIV      = 12500000,
  parameter int MAX_MIN        = 99,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       mode,
  input  logic       load,
  input  logic [6:0] preset_min,
  input  logic [5:0] preset_sec,
  input  logic       lap,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [2:0] state,
  output logic       led,
  output logic       expired
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0]    MIN_LAST   = 7'(MAX_MIN);
  localparam logic [6:0]    SEG_ZERO   = SEG_ACTIVE_LOW ? ~SEG_PATTERN[0] : SEG_PATTERN[0];

  logic [2:0]      state_q, state_d;
  logic [6:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            down_q, down_d;
  logic            led_q, led_d;
  logic            expired_q;
  logic            tick;

  logic            lap_prev_q, lap_hold_q, lap_hold_d;
  logic [6:0]      lap_min_q, lap_min_d, disp_min;
  logic [5:0]      lap_sec_q, lap_sec_d, disp_sec;
  logic [7:0]      min_bcd, sec_bcd;
  logic [3:0][3:0] digit;
  logic [3:0][6:0] pat, seg_q, seg_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    down_d  = down_q;
    led_d   = led_q;
    blink_d = blink_q;
    tick    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
        end else begin
          if (load) begin
            min_d = (preset_min > MIN_LAST) ? MIN_LAST : preset_min;
            sec_d = (preset_sec > 6'd59) ? 6'd59 : preset_sec;
          end
          if (start && !pause) begin
            state_d = ST_RUN;
            presc_d = '0;
            down_d  = mode;
          end
        end
      end
      ST_RUN: begin
        if (clear)                            state_d = ST_CLEAR;
        else if (pause || !start)             state_d = ST_PAUSE;
        // Down-counting from 00:00 expires at once rather than wrapping.
        else if (down_q && min_q == 7'd0 && sec_q == 6'd0) state_d = ST_EXPIRED;
        else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick    = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (clear)                 state_d = ST_CLEAR;
        else if (start && !pause)  state_d = ST_RUN;
      end
      ST_CLEAR:   if (!clear) state_d = ST_IDLE;
      ST_EXPIRED: if (clear)  state_d = ST_CLEAR;
      default:    state_d = ST_IDLE;
    endcase

    if (tick) begin
      if (!down_q) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          min_d = (min_q == MIN_LAST) ? 7'd0 : min_q + 7'd1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        if (sec_q == 6'd0) begin
          sec_d = 6'd59;
          min_d = min_q - 7'd1;
        end else begin
          sec_d = sec_q - 6'd1;
        end
        // The tick that lands on 00:00 expires on the same edge.
        if (min_q == 7'd0 && sec_q == 6'd1) state_d = ST_EXPIRED;
      end
    end

    if (state_d == ST_CLEAR) begin
      min_d   = 7'd0;
      sec_d   = 6'd0;
      presc_d = '0;
    end

    // LED follows the state being entered so it is already 0 on the first
    // PAUSE/IDLE/CLEAR cycle and the alarm blink starts counting from entry.
    case (state_d)
      ST_RUN: if (tick) led_d = ~led_q;
      ST_EXPIRED: begin
        if (state_q != ST_EXPIRED) begin
          led_d   = 1'b0;
          blink_d = '0;
        end else if (blink_q == BLINK_LAST) begin
          led_d   = ~led_q;
          blink_d = '0;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
      default: led_d = 1'b0;
    endcase
  end

  // Lap freeze: armed only by a rising edge seen in RUN; dropping lap or
  // leaving RUN releases it and the live count is shown again.
  always_comb begin
    lap_hold_d = lap && (state_q == ST_RUN) && (lap_hold_q || !lap_prev_q);
    lap_min_d  = lap_min_q;
    lap_sec_d  = lap_sec_q;
    if (lap_hold_d && !lap_hold_q) begin
      lap_min_d = min_q;
      lap_sec_d = sec_q;
    end
    // On the capture cycle the latched and live values coincide.
    disp_min = (lap_hold_d && lap_hold_q) ? lap_min_q : min_q;
    disp_sec = (lap_hold_d && lap_hold_q) ? lap_sec_q : sec_q;
  end

  assign min_bcd = to_bcd(disp_min);
  assign sec_bcd = to_bcd({1'b0, disp_sec});
  assign digit   = {sec_bcd[3:0], sec_bcd[7:4], min_bcd[3:0], min_bcd[7:4]};

  for (genvar g = 0; g < 4; g++) begin : g_digit
    seg7_digit_decoder u_dec (
      .digit_i (digit[g]),
      .seg_o   (pat[g])
    );
    assign seg_d[g] = SEG_ACTIVE_LOW ? ~pat[g] : pat[g];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      min_q      <= 7'd0;
      sec_q      <= 6'd0;
      presc_q    <= '0;
      blink_q    <= '0;
      down_q     <= 1'b0;
      led_q      <= 1'b0;
      expired_q  <= 1'b0;
      lap_prev_q <= 1'b0;
      lap_hold_q <= 1'b0;
      lap_min_q  <= 7'd0;
      lap_sec_q  <= 6'd0;
      seg_q      <= {4{SEG_ZERO}};
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      down_q     <= down_d;
      led_q      <= led_d;
      expired_q  <= (state_d == ST_EXPIRED);
      lap_prev_q <= lap;
      lap_hold_q <= lap_hold_d;
      lap_min_q  <= lap_min_d;
      lap_sec_q  <= lap_sec_d;
      seg_q      <= seg_d;
    end
  end

  assign seg1    = seg_q[0];
  assign seg2    = seg_q[1];
  assign seg3    = seg_q[2];
  assign seg4    = seg_q[3];
  assign state   = state_q;
  assign led     = led_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_mmss_timer_display.sv
// Bench for mmss_timer_display (TICK_DIV=4, BLINK_DIV=2, MAX_MIN=2, active-low).
// A reference model tracks the count as total seconds plus a cycle phase and
// is compared with the outputs on every falling edge; directed scenarios pin
// both the DUT and the model to hand-computed values, then randomized
// stimulus runs against the model.
module tb_mmss_timer_display;

  localparam int TD   = 4;
  localparam int BD   = 2;
  localparam int MM   = 2;
  localparam int SPAN = (MM + 1) * 60;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_CLEAR = 3, S_EXP = 4;

  // Active-low digit shapes, bit6 = g .. bit0 = a.
  localparam logic [6:0] DIGIT_AL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, clear = 1'b0, mode = 1'b0, load = 1'b0, lap = 1'b0;
  logic [6:0] preset_min = '0;
  logic [5:0] preset_sec = '0;
  logic [6:0] seg1, seg2, seg3, seg4;
  logic [2:0] state;
  logic       led, expired;

  int n_checks = 0;
  int n_errors = 0;

  mmss_timer_display #(
    .TICK_DIV       (TD),
    .BLINK_DIV      (BD),
    .MAX_MIN        (MM),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .clear      (clear),
    .mode       (mode),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .lap        (lap),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .state      (state),
    .led        (led),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] segs_of(input int total);
    int m, s;
    m = total / 60;
    s = total % 60;
    return {DIGIT_AL[m / 10], DIGIT_AL[m % 10], DIGIT_AL[s / 10], DIGIT_AL[s % 10]};
  endfunction

  function automatic int clamp(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  // ---------------- reference model ----------------
  int m_st, m_total, m_phase, m_blink, m_lap_val, m_disp;
  bit m_down, m_led, m_frozen, m_lap_prev;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    int prev_st;
    bit now_frozen;
    if (rst) begin
      m_st = S_IDLE; m_total = 0; m_phase = 0; m_blink = 0; m_lap_val = 0; m_disp = 0;
      m_down = 0; m_led = 0; m_frozen = 0; m_lap_prev = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      // Display shows the count as it stood before this edge, or the lap value.
      now_frozen = lap && (m_st == S_RUN) && (m_frozen || !m_lap_prev);
      if (now_frozen && !m_frozen) m_lap_val = m_total;
      m_disp     = now_frozen ? m_lap_val : m_total;
      m_frozen   = now_frozen;
      m_lap_prev = lap;

      prev_st = m_st;
      case (m_st)
        S_IDLE: begin
          if (clear) m_st = S_CLEAR;
          else begin
            if (load) m_total = clamp(int'(preset_min), MM) * 60 + clamp(int'(preset_sec), 59);
            if (start && !pause) begin m_st = S_RUN; m_phase = 0; m_down = mode; end
          end
        end
        S_RUN: begin
          if (clear) m_st = S_CLEAR;
          else if (pause || !start) m_st = S_PAUSE;
          else if (m_down && m_total == 0) m_st = S_EXP;
          else if (m_phase == TD - 1) begin
            m_phase = 0;
            m_led   = !m_led;
            if (m_down) begin
              m_total = m_total - 1;
              if (m_total == 0) m_st = S_EXP;
            end else begin
              m_total = (m_total + 1) % SPAN;
            end
          end else m_phase++;
        end
        S_PAUSE: if (clear) m_st = S_CLEAR; else if (start && !pause) m_st = S_RUN;
        S_CLEAR: if (!clear) m_st = S_IDLE;
        S_EXP:   if (clear) m_st = S_CLEAR;
        default: ;
      endcase

      if (m_st == S_CLEAR) begin m_total = 0; m_phase = 0; end
      if (m_st == S_EXP) begin
        if (prev_st != S_EXP) begin m_led = 0; m_blink = 0; end
        else begin
          m_blink++;
          if (m_blink == BD) begin m_blink = 0; m_led = !m_led; end
        end
      end else if (m_st != S_RUN) m_led = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("live state",   32'(state), 32'(m_st));
      check("live display", {4'b0, seg1, seg2, seg3, seg4}, {4'b0, segs_of(m_disp)});
      check("live led",     32'(led), 32'(m_led));
      check("live expired", 32'(expired), 32'(m_st == S_EXP));
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin(input string name, input int st, input int mm, input int ss, input bit exp_led);
    check({name, " state"},   32'(state), 32'(st));
    check({name, " display"}, {4'b0, seg1, seg2, seg3, seg4}, {4'b0, segs_of(mm * 60 + ss)});
    check({name, " led"},     32'(led), 32'(exp_led));
    check({name, " model state"},   32'(m_st), 32'(st));
    check({name, " model display"}, 32'(m_disp), 32'(mm * 60 + ss));
    check({name, " model led"},     32'(m_led), 32'(exp_led));
  endtask

  initial begin
    run(2); #1 rst = 1'b0;
    run(1);
    pin("reset", S_IDLE, 0, 0, 0);
    check("reset seg1 literal", 32'(seg1), 32'h40);
    check("reset expired", 32'(expired), 32'd0);

    // Up count: first tick 5 edges after start, then every 4.
    #1 mode = 1'b0; start = 1'b1;
    run(20);  pin("up four ticks", S_RUN, 0, 4, 0);
    run(700); pin("up at ceiling", S_RUN, 2, 59, 1);
    run(2);   pin("up wrap", S_RUN, 0, 0, 0);
    #1 start = 1'b0; clear = 1'b1;
    run(1);   pin("clear from run", S_CLEAR, 0, 0, 0);
    #1 clear = 1'b0;
    run(1);   pin("clear release", S_IDLE, 0, 0, 0);

    // Countdown from 00:02 to expiry and alarm blink.
    #1 load = 1'b1; preset_min = 7'd0; preset_sec = 6'd2;
    run(1);
    #1 load = 1'b0; mode = 1'b1; start = 1'b1;
    run(8);  pin("down 00:01", S_RUN, 0, 1, 1);
    run(1);  pin("expiry edge", S_EXP, 0, 1, 0);
    check("expiry flag", 32'(expired), 32'd1);
    run(2);  pin("blink on", S_EXP, 0, 0, 1);
    run(2);  pin("blink off", S_EXP, 0, 0, 0);
    #1 clear = 1'b1; start = 1'b0; mode = 1'b0;
    run(1);  pin("expired clear", S_CLEAR, 0, 0, 0);
    check("expired after clear", 32'(expired), 32'd0);
    run(1);
    #1 clear = 1'b0;
    run(1);  pin("back to idle", S_IDLE, 0, 0, 0);

    // Down mode started at 00:00 expires on the next edge.
    #1 mode = 1'b1; start = 1'b1;
    run(1);  pin("down from zero run", S_RUN, 0, 0, 0);
    run(1);  pin("down from zero expire", S_EXP, 0, 0, 0);
    #1 clear = 1'b1; start = 1'b0;
    run(1);
    #1 clear = 1'b0;
    run(1);

    // Pause keeps the prescaler phase.
    #1 mode = 1'b0; start = 1'b1;
    run(15);
    #1 pause = 1'b1;
    run(10); pin("paused", S_PAUSE, 0, 3, 0);
    #1 pause = 1'b0;
    run(2);  pin("resumed", S_RUN, 0, 3, 0);
    run(2);  pin("resume partial tick", S_RUN, 0, 4, 1);

    // Lap freeze at 00:05 across three ticks.
    run(4);
    #1 lap = 1'b1;
    run(12); pin("lap frozen", S_RUN, 0, 5, 1);
    #1 lap = 1'b0;
    run(1);  pin("lap released", S_RUN, 0, 8, 1);

    // Clear on the very cycle a tick is due.
    run(5);
    #1 clear = 1'b1;
    run(2);  pin("clear on tick", S_CLEAR, 0, 0, 0);
    #1 clear = 1'b0; start = 1'b0;
    run(1);

    // Load while running is ignored.
    #1 start = 1'b1;
    run(2);
    #1 load = 1'b1; preset_min = 7'd1; preset_sec = 6'd30;
    run(1);
    #1 load = 1'b0;
    run(4);  pin("load in run ignored", S_RUN, 0, 1, 1);
    #1 start = 1'b0; clear = 1'b1;
    run(1);
    #1 clear = 1'b0;
    run(1);

    // Out-of-range preset clamps; the seconds field is six bits, so 63 is the
    // largest out-of-range value that can be presented.
    #1 load = 1'b1; preset_min = 7'd5; preset_sec = 6'd63;
    run(1);
    #1 load = 1'b0;
    run(1);  pin("preset clamp", S_IDLE, 2, 59, 0);

    // Randomized: start and mode held per chunk, other controls per cycle.
    for (int chunk = 0; chunk < 120; chunk++) begin
      int  len;
      bit  st_lvl, md;
      len    = $urandom_range(5, 60);
      st_lvl = ($urandom_range(0, 4) != 0);
      md     = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        @(negedge clk); #1;
        rst   = ($urandom_range(0, 799) == 0);
        start = st_lvl;
        mode  = md;
        pause = ($urandom_range(0, 24) == 0);
        clear = ($urandom_range(0, 59) == 0);
        load  = ($urandom_range(0, 9) == 0);
        preset_min = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
        preset_sec = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
        if ($urandom_range(0, 11) == 0) lap = !lap;
      end
    end
    #1 rst = 1'b0;
    run(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
